// File: rtl/synchronous_fifo_fwft_if.sv
// Handshake bundle between a FIFO and its producer/consumer.
// The FIFO uses the slave modport; the side driving requests uses master.
interface synchronous_fifo_fwft_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     clear;
  logic                     write_increment;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     read_increment;
  logic [DATA_WIDTH-1:0]    read_data;
  logic                     read_valid;
  logic [ADDRESS_WIDTH:0]   data_count;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output clear, write_increment, write_data, read_increment,
    input  read_data, read_valid, data_count, full, empty,
    input  almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  clear, write_increment, write_data, read_increment,
    output read_data, read_valid, data_count, full, empty,
    output almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/synchronous_fifo_fwft.sv
// Single-clock FIFO with FWFT or registered read, occupancy count,
// programmable almost flags and sticky overflow/underflow.
module synchronous_fifo_fwft #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int FWFT               = 0,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDRESS_WIDTH) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  synchronous_fifo_fwft_if.slave bus
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);

  if (ALMOST_FULL_LEVEL <= ALMOST_EMPTY_LEVEL) begin : g_bad_levels
    $error("ALMOST_FULL_LEVEL must exceed ALMOST_EMPTY_LEVEL");
  end

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]            count;
  logic [CW-1:0]            count_nxt;
  logic                     full_q;
  logic                     empty_q;
  logic                     af_q;
  logic                     ae_q;
  logic                     ov_q;
  logic                     un_q;
  logic                     wr_ok;
  logic                     rd_ok;

  // Acceptance looks only at registered flags, so full+rd+wr drops the write.
  assign wr_ok = bus.write_increment & ~full_q;
  assign rd_ok = bus.read_increment & ~empty_q;

  always_comb begin
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset && !bus.clear && wr_ok) begin
      mem[wr_ptr] <= bus.write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_C);
      ae_q    <= (count_nxt <= AE_C);
      ov_q    <= ov_q | (bus.write_increment & full_q);
      un_q    <= un_q | (bus.read_increment & empty_q);
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Masked while empty so stale memory never shows on the bus.
    assign bus.read_data  = empty_q ? '0 : mem[rd_ptr];
    assign bus.read_valid = ~empty_q;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rv_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end else if (bus.clear) begin
        rv_q <= 1'b0;
      end else begin
        rv_q <= rd_ok;
        if (rd_ok) rd_q <= mem[rd_ptr];
      end
    end

    assign bus.read_data  = rd_q;
    assign bus.read_valid = rv_q;
  end

  assign bus.data_count   = count;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ov_q;
  assign bus.underflow    = un_q;
endmodule
